// File: rtl/op_sequencer_pkg.sv
// Shared constants for the op_sequencer: opcode values, hold lengths and
// the sequencer state encoding. The CPU decoder imports the same values.
package op_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_SAVE = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Extra cycles an opcode is re-driven after its OP cycle.
  localparam logic [1:0] HOLD_SHORT = 2'd1;
  localparam logic [1:0] HOLD_LONG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_ARG,
    S_HOLD,
    S_FIN
  } seq_state_t;

  // Number of HOLD cycles that follow the OP cycle of a non-PUSH, non-HALT opcode.
  function automatic logic [1:0] hold_cycles(input logic [3:0] op);
    logic [1:0] n;
    case (op)
      OP_SAVE, OP_LOAD: n = HOLD_LONG;
      OP_NOP, OP_POP:   n = HOLD_SHORT;
      default:          n = HOLD_SHORT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/op_sequencer_prog_store.sv
// Program nibble store: synchronous write, combinational read, no reset so
// that the program survives a sequencer reset.
module op_sequencer_prog_store #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [3:0] mem [DEPTH];

  // Write one nibble per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/op_sequencer.sv
// Plays a stored nibble program into the stack CPU input pins, stretching
// each opcode to the number of cycles the CPU needs to execute it.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [3:0]                    load_data,
  input  logic                          start,
  output logic [3:0]                    nibble_out,
  output logic                          nibble_valid,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int AW = $clog2(PROG_DEPTH);

  seq_state_t    state_reg;
  logic [AW-1:0] wptr_reg;
  logic [1:0]    hold_cnt_reg;

  logic          store_we;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_data;
  logic          last_addr;

  // Loads are only accepted while idle, and never while reset is asserted.
  assign store_we  = (state_reg == S_IDLE) && load_en && !rst;
  // Idle looks ahead at address 0; during playback at the following address.
  assign rd_addr   = (state_reg == S_IDLE) ? '0 : pc + 1'b1;
  assign last_addr = &pc;

  op_sequencer_prog_store #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) prog_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (wptr_reg),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wptr_reg     <= '0;
      hold_cnt_reg <= '0;
      pc           <= '0;
      nibble_out   <= 4'h0;
      nibble_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (load_en) begin
            wptr_reg <= wptr_reg + 1'b1;
          end else if (start) begin
            state_reg    <= S_OP;
            pc           <= '0;
            nibble_out   <= rd_data;
            nibble_valid <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_OP: begin
          if (nibble_out == OP_HALT) begin
            state_reg    <= S_FIN;
            nibble_out   <= 4'h0;
            nibble_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else if (nibble_out == OP_PUSH) begin
            // A PUSH in the last slot has no stored operand; present zero.
            state_reg <= S_ARG;
            if (last_addr) begin
              nibble_out <= 4'h0;
            end else begin
              pc         <= pc + 1'b1;
              nibble_out <= rd_data;
            end
          end else begin
            state_reg    <= S_HOLD;
            hold_cnt_reg <= hold_cycles(nibble_out) - 2'd1;
          end
        end
        S_ARG, S_HOLD: begin
          if (state_reg == S_HOLD && hold_cnt_reg != 2'd0) begin
            hold_cnt_reg <= hold_cnt_reg - 2'd1;
          end else if (last_addr) begin
            state_reg    <= S_FIN;
            nibble_out   <= 4'h0;
            nibble_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            state_reg  <= S_OP;
            pc         <= pc + 1'b1;
            nibble_out <= rd_data;
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
